pipe_skid_buffer: RTL and testbench
===================================

Name: pipe_skid_buffer

Overview:
- Parametrised successor to the plain inter-stage pipeline register used between the IF/ID/EX/MEM/WB stages.
- Adds a valid/ready handshake, a two-entry skid so backpressure never creates a combinational ready path, synchronous flush with bubble insertion, a global hold, and a saturating backpressure counter.
- Drops in wherever a stage buffer sits, for example between decode and execute for load-use stalls and branch flushes.

Parameters:
- WIDTH, 64, payload width in bits.
- BUBBLE_VALUE, {WIDTH{1'b0}}, payload presented when empty, after flush, and after reset. Control bits at 0 mean NOP.
- CNT_W, 16, width of the backpressure cycle counter.

Ports:
- Clk  in  1  rising-edge clock for all state.
- Rst  in  1  synchronous, active-high reset.
- Flush  in  1  discard all held entries this cycle.
- Hold  in  1  freeze the buffer; no transfer in or out.
- in_valid  in  1  upstream payload valid.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  buffer can accept in_data this cycle.
- out_valid  out  1  out_data holds a real instruction.
- out_data  out  WIDTH  payload to downstream stage.
- out_ready  in  1  downstream accepts out_data this cycle.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (or Hold=1 while out_valid=1).

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Rst. Every register updates only on the rising Clk edge.
- Storage: main register (drives out_data) and skid register.
- State: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
- Reset values: state=EMPTY, main=skid=BUBBLE_VALUE, out_valid=0, occupancy=0, stall_cnt=0, in_ready=1 in the cycle after reset.
- out_valid = (state != EMPTY). occupancy encodes state directly.
- in_ready = (state != FULL) & ~Hold. The only combinational dependence is on Hold; no in-to-out combinational path.
- Transfers: acc = in_valid & in_ready; dep = out_valid & out_ready & ~Hold.
- EMPTY:
  - acc -> ONE, main <= in_data.
  - else stay EMPTY, main stays BUBBLE_VALUE.
- ONE:
  - acc & dep -> ONE, main <= in_data.
  - acc & ~dep -> FULL, skid <= in_data.
  - ~acc & dep -> EMPTY, main <= BUBBLE_VALUE.
  - else hold.
- FULL:
  - dep -> ONE, main <= skid, skid <= BUBBLE_VALUE.
  - else hold. acc is impossible because in_ready=0.
- Latency: 1 cycle from accepted input to out_valid when empty. Throughput is one transfer per cycle with out_ready held high.
- Ordering is strict FIFO. The skid entry is never emitted before main.
- Hold=1: state, main and skid frozen. in_ready=0. No dep counts even if out_ready=1. stall_cnt increments if out_valid=1.
- Flush=1 (priority over Hold, acc, dep):
  - next state=EMPTY, main=skid=BUBBLE_VALUE.
  - An input accepted in the same cycle is discarded.
  - A dep in the same cycle still counts as consumed downstream.
  - stall_cnt is unaffected.
- Rst has priority over Flush and also clears stall_cnt. Reset mid-transfer drops all entries.
- stall_cnt increments by 1 when out_valid & (~out_ready | Hold) & ~Flush, and saturates at all-ones with no wrap.
- out_data must equal BUBBLE_VALUE whenever out_valid=0.

Decomposition:
- Shared package/include: state encodings (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2) and a default NOP bubble constant for the ID/EX payload layout.
- Sub-module: sat_counter (parametrised width, increment enable, synchronous clear, saturation) for stall_cnt. Reusable for other performance counters.
- The skid FSM stays inline.

Test Plan:
- Setup for all scenarios: WIDTH=16, BUBBLE_VALUE=16'h0000.
- Reset then stream: Rst 1 cycle; in_valid=1 with 16'h0001..16'h0005 on consecutive cycles, out_ready=1. Required: out_data 0001..0005 on cycles 1..5, occupancy=1, in_ready=1 throughout, stall_cnt=0.
- Backpressure fill: send 16'hAAAA, then 16'hBBBB with out_ready=0. Required: occupancy 1 then 2, in_ready=0, out_data=AAAA. Then out_ready=1: AAAA then BBBB, then out_valid=0 and out_data=0000. stall_cnt=1.
- Flush while FULL: state FULL holding 1111/2222; Flush=1 with in_valid=1 and 3333. Required next cycle: occupancy=0, out_valid=0, out_data=0000; 3333 is never emitted.
- Hold: ONE holding 4444, Hold=1 for 3 cycles with out_ready=1 and in_valid=1. Required: in_ready=0, out_data=4444 stable, stall_cnt advances by 3. Release: 4444 consumed next cycle.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1. Required: stall_cnt stops at 4'hF with no wrap. Rst clears it to 0.
- Random: random in_valid/out_ready/Hold/Flush over 10k cycles against a FIFO scoreboard. Required: no loss or duplication except entries dropped by Flush, order preserved, and out_data=0000 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_skid_buffer_pkg.sv
// pipe_skid_buffer_pkg: shared state encoding and the NOP bubble for the ID/EX payload
package pipe_skid_buffer_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
  localparam logic [63:0] IDEX_NOP = 64'h0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else if (en_i && !(&cnt_q)) cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready stage register with flush, hold and stall counter
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int                 WIDTH        = 64,
  parameter logic [WIDTH-1:0]   BUBBLE_VALUE = WIDTH'(IDEX_NOP),
  parameter int                 CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  state_e           state_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             acc, dep;
  assign out_valid_o = state_q != ST_EMPTY;
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;
  assign in_ready_o  = (state_q != ST_FULL) && !hold_i;
  assign acc         = in_valid_i && in_ready_o;
  assign dep         = out_valid_o && out_ready_i && !hold_i;
  // hold needs no branch of its own: it already forces acc and dep low
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VALUE;
      skid_q  <= BUBBLE_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          main_q  <= in_data_i;
          state_q <= ST_ONE;
        end
        ST_ONE: if (acc && dep) main_q <= in_data_i;
        else if (acc) begin
          skid_q  <= in_data_i;
          state_q <= ST_FULL;
        end else if (dep) begin
          main_q  <= BUBBLE_VALUE;
          state_q <= ST_EMPTY;
        end
        ST_FULL: if (dep) begin
          main_q  <= skid_q;
          skid_q  <= BUBBLE_VALUE;
          state_q <= ST_ONE;
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= BUBBLE_VALUE;
          skid_q  <= BUBBLE_VALUE;
        end
      endcase
    end
  end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (out_valid_o && (!out_ready_i || hold_i) && !flush_i),
    .cnt_o (stall_cnt_o)
  );
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed table, hand sequences and random run against a queue model
module tb_pipe_skid_buffer;
  logic        clk = 1'b0;
  logic        rst, flush, hold, iv, ordy;
  logic [15:0] din;
  logic        ir, ov, ir2, ov2;
  logic [15:0] od, od2, cnt;
  logic [1:0]  occ, occ2;
  logic [3:0]  cnt2;
  int          total = 0, bad = 0;
  logic [15:0] q[$];
  int          mcnt = 0;

  always #5 clk = ~clk;

  pipe_skid_buffer #(.WIDTH(16), .BUBBLE_VALUE(16'h0000), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .hold_i(hold), .in_valid_i(iv),
    .in_data_i(din), .in_ready_o(ir), .out_valid_o(ov), .out_data_o(od),
    .out_ready_i(ordy), .occupancy_o(occ), .stall_cnt_o(cnt));

  pipe_skid_buffer #(.WIDTH(16), .BUBBLE_VALUE(16'h0000), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .hold_i(hold), .in_valid_i(iv),
    .in_data_i(din), .in_ready_o(ir2), .out_valid_o(ov2), .out_data_o(od2),
    .out_ready_i(ordy), .occupancy_o(occ2), .stall_cnt_o(cnt2));

  typedef struct {
    logic r, f, h, v; logic [15:0] d; logic o;
    logic c; logic ev; logic [15:0] ed; logic er; logic [1:0] oc; logic [15:0] cn;
  } vec_t;
  vec_t tbl[30];

  function automatic vec_t vv(logic r, f, h, v, logic [15:0] d, logic o,
                              logic c, ev, logic [15:0] ed, logic er, logic [1:0] oc, logic [15:0] cn);
    vec_t x;
    x.r = r; x.f = f; x.h = h; x.v = v; x.d = d; x.o = o;
    x.c = c; x.ev = ev; x.ed = ed; x.er = er; x.oc = oc; x.cn = cn;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input logic r, f, h, v, input logic [15:0] d, input logic o);
    rst = r; flush = f; hold = h; iv = v; din = d; ordy = o;
    #1;
  endtask

  // model: a bounded queue of at most two entries, updated from the inputs of this cycle
  task automatic tick();
    bit acc, dep;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (q.size() > 0 && (!ordy || hold) && !flush) mcnt++;
      acc = iv && q.size() < 2 && !hold;
      dep = q.size() > 0 && ordy && !hold;
      if (flush) q.delete();
      else begin
        if (dep) void'(q.pop_front());
        if (acc) q.push_back(din);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_chk();
    int sz = q.size();
    logic [15:0] ed = sz > 0 ? q[0] : 16'h0000;
    chk("rnd_valid", ov, sz > 0);
    chk("rnd_data", od, ed);
    chk("rnd_ready", ir, sz < 2 && !hold);
    chk("rnd_occ", occ, sz);
    chk("rnd_cnt16", cnt, mcnt > 65535 ? 65535 : mcnt);
    chk("rnd_cnt4", cnt2, mcnt > 15 ? 15 : mcnt);
    chk("rnd_data_sat", od2, ed);
  endtask

  initial begin
    //              r  f  h  v  d        o   c  ev ed       er oc cn
    tbl[0]  = vv(1, 0, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 0, 0);
    tbl[1]  = vv(0, 0, 0, 1, 16'h0001, 1,  1, 0, 16'h0000, 1, 0, 0);
    tbl[2]  = vv(0, 0, 0, 1, 16'h0002, 1,  1, 1, 16'h0001, 1, 1, 0);
    tbl[3]  = vv(0, 0, 0, 1, 16'h0003, 1,  1, 1, 16'h0002, 1, 1, 0);
    tbl[4]  = vv(0, 0, 0, 1, 16'h0004, 1,  1, 1, 16'h0003, 1, 1, 0);
    tbl[5]  = vv(0, 0, 0, 1, 16'h0005, 1,  1, 1, 16'h0004, 1, 1, 0);
    tbl[6]  = vv(0, 0, 0, 0, 16'h0000, 1,  1, 1, 16'h0005, 1, 1, 0);
    tbl[7]  = vv(0, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 0);
    tbl[8]  = vv(0, 0, 0, 1, 16'hAAAA, 0,  1, 0, 16'h0000, 1, 0, 0);
    tbl[9]  = vv(0, 0, 0, 1, 16'hBBBB, 0,  1, 1, 16'hAAAA, 1, 1, 0);
    tbl[10] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 1, 16'hAAAA, 0, 2, 1);
    tbl[11] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 1, 16'hBBBB, 1, 1, 1);
    tbl[12] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 1);
    tbl[13] = vv(0, 0, 0, 1, 16'h1111, 0,  1, 0, 16'h0000, 1, 0, 1);
    tbl[14] = vv(0, 0, 0, 1, 16'h2222, 0,  1, 1, 16'h1111, 1, 1, 1);
    tbl[15] = vv(0, 1, 0, 1, 16'h3333, 0,  1, 1, 16'h1111, 0, 2, 2);
    tbl[16] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 2);
    tbl[17] = vv(0, 0, 0, 1, 16'h5555, 0,  1, 0, 16'h0000, 1, 0, 2);
    tbl[18] = vv(0, 1, 0, 1, 16'h6666, 1,  1, 1, 16'h5555, 1, 1, 2);
    tbl[19] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 2);
    tbl[20] = vv(0, 0, 0, 1, 16'h4444, 1,  1, 0, 16'h0000, 1, 0, 2);
    tbl[21] = vv(0, 0, 1, 1, 16'h7777, 1,  1, 1, 16'h4444, 0, 1, 2);
    tbl[22] = vv(0, 0, 1, 1, 16'h7777, 1,  1, 1, 16'h4444, 0, 1, 3);
    tbl[23] = vv(0, 0, 1, 1, 16'h7777, 1,  1, 1, 16'h4444, 0, 1, 4);
    tbl[24] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 1, 16'h4444, 1, 1, 5);
    tbl[25] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 5);
    tbl[26] = vv(1, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 5);
    tbl[27] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 0);
    tbl[28] = vv(0, 0, 1, 1, 16'h8888, 1,  1, 0, 16'h0000, 0, 0, 0);
    tbl[29] = vv(0, 0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].h, tbl[i].v, tbl[i].d, tbl[i].o);
      if (tbl[i].c) begin
        chk($sformatf("vec%0d_valid", i), ov, tbl[i].ev);
        chk($sformatf("vec%0d_data", i), od, tbl[i].ed);
        chk($sformatf("vec%0d_ready", i), ir, tbl[i].er);
        chk($sformatf("vec%0d_occ", i), occ, tbl[i].oc);
        chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cn);
      end
      tick();
    end

    // saturation of the 4-bit counter under a long stall, then reset clears it
    drive(1, 0, 0, 0, 16'h0000, 0); tick();
    drive(0, 0, 0, 1, 16'h9999, 0); tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 16'h0000, 0);
      chk($sformatf("sat%0d_cnt4", k), cnt2, k > 15 ? 15 : k);
      chk($sformatf("sat%0d_cnt16", k), cnt, k);
      chk($sformatf("sat%0d_data", k), od2, 16'h9999);
      tick();
    end
    drive(1, 0, 0, 0, 16'h0000, 0);
    chk("sat_pre_rst", cnt2, 4'hF);
    tick();
    drive(0, 0, 0, 0, 16'h0000, 0);
    chk("sat_rst_cnt4", cnt2, 0);
    chk("sat_rst_cnt16", cnt, 0);
    chk("sat_rst_valid", ov2, 0);
    tick();

    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            16'($urandom), $urandom_range(0, 2) != 0);
      model_chk();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
